uart_word_tx_serializer: RTL and testbench
==========================================

# uart_word_tx_serializer

Downstream of the UART/pipeline debug interface: accepts one 32-bit debug word at a time (register, data-memory, latch and end-of-program words) and serializes it into bytes for the UART transmitter. Drives the interface's buffer-empty input, so it is the sole flow-control point between word-level debug traffic and the byte-level UART TX. One word in flight; no FIFO.

## Interface
- WORD_WIDTH, 32, word width; must be a multiple of 8.
- BYTE_WIDTH, 8, UART byte width.
- MSB_FIRST, 1, 1 = bits [31:24] sent first (matches ASCII command packing); 0 = LSB byte first.
- COUNT_WIDTH, 16, width of words-sent counter.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; synchronous, active-low. One clock; all state updates on rising edge of i_clk.
- i_word  in  WORD_WIDTH  word to send; sampled only when i_start is high.
- i_start  in  1  one-cycle request; fed from the interface's buffer-start output.
- o_empty  out  1  ready for a new word; fed to the interface's buffer-empty input.
- o_tx_data  out  BYTE_WIDTH  byte to UART TX.
- o_tx_start  out  1  one-cycle pulse: UART TX loads o_tx_data.
- i_tx_done  in  1  one-cycle pulse from UART TX: current byte finished.
- o_overrun  out  1  sticky: i_start seen while busy.
- o_words_sent  out  COUNT_WIDTH  completed words, wraps.

## Operation
- States: IDLE, WAIT_DONE. Byte index register 0..NBYTES-1 (NBYTES = WORD_WIDTH/BYTE_WIDTH, plus 1 with checksum).
- IDLE, i_start=1: capture i_word into shift register; o_tx_data <= first byte; o_tx_start <= 1; index <= 0; -> WAIT_DONE.
- WAIT_DONE, i_tx_done=1, index < last: index+1; o_tx_data <= next byte; o_tx_start <= 1; stay.
- WAIT_DONE, i_tx_done=1, index = last: o_words_sent+1; -> IDLE.
- o_tx_start is high for exactly one cycle per byte; low otherwise.
- o_empty = (state == IDLE) && !i_start (combinational). Required: the interface samples empty on the same edge that we capture its start pulse; empty must already read 0 then, else it issues a duplicate word.
- i_start while state != IDLE: word dropped, o_overrun <= 1 (sticky until reset); transfer in progress unaffected.
- i_tx_done in IDLE: ignored.
- o_words_sent wraps 2^COUNT_WIDTH-1 -> 0.
- 0xFFFFFFFF end-of-program word is not special; sent as four 0xFF bytes.

## Timing
- Reset values: state IDLE, o_tx_data 0, o_tx_start 0, o_overrun 0, o_words_sent 0, index 0; o_empty 1 (when i_start low).
- Reset mid-transfer: abandon word immediately; next cycle all outputs at reset values; no further o_tx_start.
- Latency: i_start sampled at edge E0 -> o_tx_start high in cycle after E0.
- i_tx_done sampled at edge En -> next o_tx_start high in cycle after En (no gap cycle).
- Last i_tx_done at edge Ef -> o_empty high in cycle after Ef; new i_start accepted that cycle.
- Minimum word period: NBYTES UART byte times + 1 cycle.

## Configuration
- TX_WORD_CHECKSUM_EN defined: after last data byte, one extra byte = XOR of all data bytes; word counted and IDLE entered only after its i_tx_done.
- Undefined: exactly NBYTES data bytes per word; no checksum logic present.

## Structure
- Shared package: state encoding localparams (IDLE, WAIT_DONE), NBYTES derivation, default WORD_WIDTH/BYTE_WIDTH constants shared with the UART/pipeline interface.
- Single module; byte selection is a shift register inside it. No sub-module needed.

## Test plan
- Reset, i_start=1 with i_word=0x636F6E74, MSB_FIRST=1, i_tx_done after 10 cycles each -> bytes 0x63,0x6F,0x6E,0x74, four o_tx_start pulses, o_words_sent=1, o_empty high after 4th done.
- Same word, MSB_FIRST=0 -> bytes 0x74,0x6E,0x6F,0x63.
- i_start pulse while serializing 0x11223344 with word 0xAABBCCDD -> o_overrun=1, only 0x11,0x22,0x33,0x44 transmitted.
- Interface-model handshake, back-to-back 32 register words -> exactly 128 bytes, no duplicates, o_empty=0 on every start-capture edge.
- i_reset_n low after 2nd byte of 0xDEADBEEF -> next cycle o_tx_start=0, o_tx_data=0, o_empty=1; later i_tx_done ignored.
- TX_WORD_CHECKSUM_EN, word 0xDEADBEEF -> bytes 0xDE,0xAD,0xBE,0xEF,0x22; o_words_sent increments only after 5th done.

Source files
------------

// File: rtl/uart_word_tx_serializer_pkg.sv
// Shared definitions for the debug-word UART serializer and the
// UART/pipeline debug interface that feeds it.
//   - Default word/byte widths used on both sides of the buffer handshake.
//   - FSM state encoding (IDLE, WAIT_DONE).
//   - Helper that derives the number of data bytes per word.
package uart_word_tx_serializer_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  function automatic int calc_nbytes(input int word_width, input int byte_width);
    return word_width / byte_width;
  endfunction

endpackage

// File: rtl/uart_word_tx_serializer.sv
// uart_word_tx_serializer
// Takes one debug word at a time from the UART/pipeline debug interface and
// hands it byte by byte to the UART transmitter. One word in flight, no FIFO;
// o_empty is the only flow-control signal back to the interface.
//
// Optional feature: define TX_WORD_CHECKSUM_EN to append one extra byte per
// word holding the XOR of all data bytes.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_reset_n    synchronous active-low reset
//   i_word       word to send, sampled only while i_start is high
//   i_start      one-cycle request from the interface's buffer-start output
//   o_empty      ready for a new word (combinational, drops with i_start)
//   o_tx_data    byte presented to the UART transmitter
//   o_tx_start   one-cycle pulse telling the transmitter to load o_tx_data
//   i_tx_done    one-cycle pulse from the transmitter: byte finished
//   o_overrun    sticky flag: a word arrived while busy and was dropped
//   o_words_sent count of completed words, wraps
module uart_word_tx_serializer
  import uart_word_tx_serializer_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [WORD_WIDTH-1:0]  i_word,
  input  logic                   i_start,
  output logic                   o_empty,
  output logic [BYTE_WIDTH-1:0]  o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_overrun,
  output logic [COUNT_WIDTH-1:0] o_words_sent
);

  localparam int NBYTES = calc_nbytes(WORD_WIDTH, BYTE_WIDTH);
`ifdef TX_WORD_CHECKSUM_EN
  localparam int NBYTES_TOT = NBYTES + 1;
`else
  localparam int NBYTES_TOT = NBYTES;
`endif
  localparam int IDX_W = (NBYTES_TOT > 1) ? $clog2(NBYTES_TOT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES_TOT - 1);

  // Byte that goes out next from a (partially shifted) word.
  function automatic logic [BYTE_WIDTH-1:0] head_byte(input logic [WORD_WIDTH-1:0] w);
    return MSB_FIRST ? w[WORD_WIDTH-1 -: BYTE_WIDTH] : w[BYTE_WIDTH-1:0];
  endfunction

  // Drop the byte just sent so the following one sits at the head.
  function automatic logic [WORD_WIDTH-1:0] advance(input logic [WORD_WIDTH-1:0] w);
    return MSB_FIRST ? (w << BYTE_WIDTH) : (w >> BYTE_WIDTH);
  endfunction

`ifdef TX_WORD_CHECKSUM_EN
  function automatic logic [BYTE_WIDTH-1:0] xor_bytes(input logic [WORD_WIDTH-1:0] w);
    logic [BYTE_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < NBYTES; i++) acc = acc ^ w[i*BYTE_WIDTH +: BYTE_WIDTH];
    return acc;
  endfunction
`endif

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d;
  logic [BYTE_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d;
  logic                   overrun_q, overrun_d;
`ifdef TX_WORD_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]  csum_q, csum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      idx_q      <= '0;
      words_q    <= '0;
      overrun_q  <= 1'b0;
`ifdef TX_WORD_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      overrun_q  <= overrun_d;
`ifdef TX_WORD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    idx_d      = idx_q;
    words_d    = words_q;
    // A request while busy is dropped; the word in flight is untouched.
    overrun_d  = overrun_q | (i_start && (state_q != IDLE));
`ifdef TX_WORD_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          // First byte goes straight to the output; the shift register keeps
          // the remaining bytes already aligned at its head.
          tx_data_d  = head_byte(i_word);
          shift_d    = advance(i_word);
          tx_start_d = 1'b1;
          idx_d      = '0;
          state_d    = WAIT_DONE;
`ifdef TX_WORD_CHECKSUM_EN
          csum_d     = xor_bytes(i_word);
`endif
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            words_d = words_q + 1'b1;
            state_d = IDLE;
          end else begin
            idx_d      = idx_q + 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = head_byte(shift_q);
            shift_d    = advance(shift_q);
`ifdef TX_WORD_CHECKSUM_EN
            // After the last data byte the checksum byte goes out instead.
            if (idx_q == IDX_W'(NBYTES - 1)) tx_data_d = csum_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Must fall in the same cycle as i_start so the interface never sees
  // "empty" on the edge that captures its request.
  assign o_empty      = (state_q == IDLE) && !i_start;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_overrun    = overrun_q;
  assign o_words_sent = words_q;

endmodule

// File: tb/tb_uart_word_tx_serializer.sv
// Directed bench for uart_word_tx_serializer: an MSB-first and an LSB-first
// instance share clock, reset, word bus and the UART tx_done line. Expected
// bytes are queued when a word is offered and popped as o_tx_start pulses.
module tb_uart_word_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = '0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        man_done = 1'b0, model_done = 1'b0;
  logic        tx_done;
  logic        empty0, empty1, txs0, txs1, ovr0, ovr1;
  logic [7:0]  data0, data1;
  logic [15:0] words0, words1;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          total = 0, bad = 0;
  int          nb0 = 0, nb1 = 0;
  bit          uart_en = 1'b0;
  int          gap = 10, cnt = 0;

  assign tx_done = man_done | model_done;

  always #5 clk = ~clk;

  uart_word_tx_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1), .COUNT_WIDTH(16)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_word(word), .i_start(start0), .o_empty(empty0),
    .o_tx_data(data0), .o_tx_start(txs0), .i_tx_done(tx_done), .o_overrun(ovr0), .o_words_sent(words0));

  uart_word_tx_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0), .COUNT_WIDTH(16)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_word(word), .i_start(start1), .o_empty(empty1),
    .o_tx_data(data1), .o_tx_start(txs1), .i_tx_done(tx_done), .o_overrun(ovr1), .o_words_sent(words1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every o_tx_start must match the next queued byte.
  always @(negedge clk) begin
    if (txs0 === 1'b1) begin
      nb0++;
      total++;
      assert (q0.size() != 0) else begin
        bad++;
        $error("FAIL dut0_extra_byte observed=%0h expected=none", data0);
      end
      if (q0.size() != 0) check("dut0_byte", {24'h0, data0}, {24'h0, q0.pop_front()});
    end
    if (txs1 === 1'b1) begin
      nb1++;
      total++;
      assert (q1.size() != 0) else begin
        bad++;
        $error("FAIL dut1_extra_byte observed=%0h expected=none", data1);
      end
      if (q1.size() != 0) check("dut1_byte", {24'h0, data1}, {24'h0, q1.pop_front()});
    end
  end

  // UART TX model: tx_done pulse 'gap' cycles after each o_tx_start.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!uart_en || !rst_n) cnt = 0;
    else if (txs0 === 1'b1 || txs1 === 1'b1) cnt = gap;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) model_done = 1'b1;
    end
  end

  task automatic push_word(input int which, input logic [31:0] w, input bit msb);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = msb ? w[31 - 8*i -: 8] : w[8*i +: 8];
      if (which == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic wait_words(input int which, input logic [15:0] target, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (((which == 0) ? words0 : words1) == target) break;
      @(negedge clk);
    end
    check(tag, {16'h0, (which == 0) ? words0 : words1}, {16'h0, target});
  endtask

  int base;
  logic [31:0] w;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'h0, txs0}, 32'h0);
    check("rst_tx_data", {24'h0, data0}, 32'h0);
    check("rst_overrun", {31'h0, ovr0}, 32'h0);
    check("rst_words", {16'h0, words0}, 32'h0);
    check("rst_empty", {31'h0, empty0}, 32'h1);
    check("rst_empty1", {31'h0, empty1}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB first, done 10 cycles after each byte
    uart_en = 1'b1; gap = 10;
    word = 32'h636F6E74;
    push_word(0, word, 1'b1);
    start0 = 1'b1;
    #1 check("empty_low_with_start", {31'h0, empty0}, 32'h0);
    @(negedge clk);
    start0 = 1'b0;
    check("start_latency", {31'h0, txs0}, 32'h1);
    wait_words(0, 16'd1, 200, "msb_words");
    check("msb_empty_after", {31'h0, empty0}, 32'h1);
    check("msb_nbytes", nb0, 4);
    check("msb_queue", q0.size(), 0);

    // LSB first
    push_word(1, word, 1'b0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_words(1, 16'd1, 200, "lsb_words");
    check("lsb_nbytes", nb1, 4);
    check("lsb_queue", q1.size(), 0);

    // Overrun: second word dropped
    word = 32'h11223344;
    push_word(0, word, 1'b1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    word = 32'hAABBCCDD;
    start0 = 1'b1;
    #1 check("busy_empty", {31'h0, empty0}, 32'h0);
    @(negedge clk);
    start0 = 1'b0;
    check("overrun_set", {31'h0, ovr0}, 32'h1);
    wait_words(0, 16'd2, 200, "ovr_words");
    check("ovr_nbytes", nb0, 8);
    check("ovr_sticky", {31'h0, ovr0}, 32'h1);
    check("ovr_queue", q0.size(), 0);

    // Back-to-back interface handshake, 32 words, fastest UART
    gap = 1;
    base = nb0;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 50 && !empty0; k++) @(negedge clk);
      w = $urandom;
      word = w;
      push_word(0, w, 1'b1);
      start0 = 1'b1;
      #1 check("b2b_empty_at_capture", {31'h0, empty0}, 32'h0);
      @(negedge clk);
      start0 = 1'b0;
    end
    wait_words(0, 16'd34, 400, "b2b_words");
    check("b2b_nbytes", nb0 - base, 128);
    check("b2b_queue", q0.size(), 0);

    // Reset after the second byte of 0xDEADBEEF
    uart_en = 1'b0;
    word = 32'hDEADBEEF;
    q0.push_back(8'hDE);
    q0.push_back(8'hAD);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("mid_second_start", {31'h0, txs0}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_tx_start", {31'h0, txs0}, 32'h0);
    check("mid_rst_tx_data", {24'h0, data0}, 32'h0);
    check("mid_rst_empty", {31'h0, empty0}, 32'h1);
    check("mid_rst_overrun", {31'h0, ovr0}, 32'h0);
    check("mid_rst_words", {16'h0, words0}, 32'h0);
    base = nb0;
    for (int i = 0; i < 3; i++) begin
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      @(negedge clk);
    end
    check("done_ignored_nbytes", nb0 - base, 0);
    check("done_ignored_empty", {31'h0, empty0}, 32'h1);
    check("done_ignored_words", {16'h0, words0}, 32'h0);

    // End-of-program word, with or without checksum byte
    uart_en = 1'b1; gap = 3;
    base = nb0;
    word = 32'hFFFFFFFF;
    push_word(0, word, 1'b1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_words(0, 16'd1, 200, "eop_words");
    check("eop_nbytes", nb0 - base, 4);

    base = nb0;
    word = 32'hDEADBEEF;
    push_word(0, word, 1'b1);
`ifdef TX_WORD_CHECKSUM_EN
    q0.push_back(8'h22);
`endif
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
`ifdef TX_WORD_CHECKSUM_EN
    for (int k = 0; k < 200 && (nb0 - base) < 5; k++) @(negedge clk);
    check("last_byte_count", nb0 - base, 5);
`else
    for (int k = 0; k < 200 && (nb0 - base) < 4; k++) @(negedge clk);
    check("last_byte_count", nb0 - base, 4);
`endif
    check("not_counted_before_last_done", {16'h0, words0}, 32'h1);
    wait_words(0, 16'd2, 200, "final_words");
    check("final_queue0", q0.size(), 0);
    check("final_queue1", q1.size(), 0);
    check("final_empty", {31'h0, empty0}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
